// File: rtl/rate_shaper_if.sv
// rate_shaper_if: beat-stream valid/ready bus carrying message framing (sop/eop/empty).
interface rate_shaper_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EW = $clog2(DATA_WIDTH_IN_BYTES);
    logic                             valid;
    logic                             ready;
    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             sop;
    logic                             eop;
    logic [EW-1:0]                    empty;
    modport master(output valid, data, sop, eop, empty, input ready);
    modport slave(input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/rate_shaper.sv
// rate_shaper: token-bucket shaper that admits a new message only on non-negative byte credit,
// forwards it contiguously through one output register, and keeps message/throttle statistics.
module rate_shaper #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int TOKEN_WIDTH         = 24,
    parameter int MSG_CNT_WIDTH       = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_enable_i,
    input  logic [TOKEN_WIDTH-1:0]   cfg_rate_i,
    input  logic [TOKEN_WIDTH-1:0]   cfg_burst_i,
    rate_shaper_if.slave             in_i,
    rate_shaper_if.master            out_o,
    output logic [MSG_CNT_WIDTH-1:0] stat_msg_count_o,
    output logic [31:0]              stat_throttle_o,
    output logic                     err_pulse_o
);
    localparam int EW = $clog2(DATA_WIDTH_IN_BYTES);
    localparam int CW = TOKEN_WIDTH + 2;
    localparam logic [EW:0] FULL = (EW + 1)'(DATA_WIDTH_IN_BYTES);
    localparam logic signed [CW-1:0] FLOOR = {2'b11, {TOKEN_WIDTH{1'b0}}};

    typedef enum logic {IDLE, IN_MSG} state_t;

    state_t                           state_q, state_d;
    logic signed [TOKEN_WIDTH:0]      credit_q, credit_d;
    logic                             out_valid_q, out_sop_q, out_eop_q, err_q;
    logic [8*DATA_WIDTH_IN_BYTES-1:0] out_data_q;
    logic [EW-1:0]                    out_empty_q;
    logic [MSG_CNT_WIDTH-1:0]         msg_cnt_q;
    logic [31:0]                      throttle_q;
    logic                             free, gate, acc, drop, fwd, throttled;
    logic [EW:0]                      consumed;
    logic signed [CW-1:0]             sum, burst, refill, charged;

    always_comb begin
        free      = !out_valid_q || out_o.ready;
        gate      = state_q == IN_MSG || !cfg_enable_i || !credit_q[TOKEN_WIDTH];
        acc       = in_i.valid && free && gate;
        drop      = acc && state_q == IDLE && !in_i.sop;
        fwd       = acc && !drop;
        throttled = cfg_enable_i && state_q == IDLE && in_i.valid && in_i.sop && credit_q[TOKEN_WIDTH];
        consumed  = !(fwd && cfg_enable_i) ? '0 : in_i.eop ? FULL - {1'b0, in_i.empty} : FULL;
        // refill is clamped to the bucket depth before the charge is taken off
        sum       = CW'(credit_q) + $signed(CW'(cfg_rate_i));
        burst     = $signed(CW'(cfg_burst_i));
        refill    = sum > burst ? burst : sum;
        charged   = refill - $signed(CW'(consumed));
        credit_d  = !cfg_enable_i ? {1'b0, cfg_burst_i} :
                    charged < FLOOR ? FLOOR[TOKEN_WIDTH:0] : charged[TOKEN_WIDTH:0];
        state_d   = !acc ? state_q :
                    state_q == IDLE ? (in_i.sop && !in_i.eop ? IN_MSG : IDLE) :
                    (in_i.eop ? IDLE : IN_MSG);
    end

    assign in_i.ready       = free && gate;
    assign out_o.valid      = out_valid_q;
    assign out_o.data       = out_data_q;
    assign out_o.sop        = out_sop_q;
    assign out_o.eop        = out_eop_q;
    assign out_o.empty      = out_empty_q;
    assign stat_msg_count_o = msg_cnt_q;
    assign stat_throttle_o  = throttle_q;
    assign err_pulse_o      = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            credit_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            msg_cnt_q   <= '0;
            throttle_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            // a stray beat in IDLE and a sop inside a message are both framing errors
            err_q    <= acc && (state_q == IDLE ? !in_i.sop : in_i.sop);
            if (fwd) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_i.data;
                out_sop_q   <= in_i.sop && state_q == IDLE;
                out_eop_q   <= in_i.eop;
                out_empty_q <= in_i.empty;
            end else if (out_o.ready) begin
                out_valid_q <= 1'b0;
            end
            if (fwd && in_i.eop)
                msg_cnt_q <= msg_cnt_q + MSG_CNT_WIDTH'(1);
            if (throttled && !(&throttle_q))
                throttle_q <= throttle_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_rate_shaper.sv
// tb_rate_shaper: directed and random stimulus checked cycle by cycle against a
// token-bucket reference model kept in plain integer arithmetic.
module tb_rate_shaper;
    localparam int DW = 16, TW = 24, MW = 14, EW = $clog2(DW);
    localparam longint FLR = -(longint'(1) << TW);

    logic          clk = 1'b0, rst = 1'b1;
    logic          en = 1'b0;
    logic [TW-1:0] rate = '0, burst = '0;
    logic [MW-1:0] msg_cnt;
    logic [31:0]   thr;
    logic          err;
    int            total = 0, bad = 0;

    rate_shaper_if #(.DATA_WIDTH_IN_BYTES(DW)) s_if ();
    rate_shaper_if #(.DATA_WIDTH_IN_BYTES(DW)) m_if ();

    rate_shaper #(.DATA_WIDTH_IN_BYTES(DW), .TOKEN_WIDTH(TW), .MSG_CNT_WIDTH(MW)) dut (
        .clk(clk), .rst(rst), .cfg_enable_i(en), .cfg_rate_i(rate), .cfg_burst_i(burst),
        .in_i(s_if), .out_o(m_if), .stat_msg_count_o(msg_cnt), .stat_throttle_o(thr),
        .err_pulse_o(err)
    );

    always #5 clk = ~clk;

    longint          cr, thrc;
    bit              in_msg, ev, esop, eeop, eerr, acc_seen;
    logic [8*DW-1:0] edata;
    logic [EW-1:0]   eempty;
    int              mcnt, cyc_n = 0, last_sop = 0, gap = 0, sops = 0, eops = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        cr = 0; thrc = 0; in_msg = 0; ev = 0; esop = 0; eeop = 0; eerr = 0;
        edata = '0; eempty = '0; mcnt = 0;
    endtask

    task automatic zero_chk();
        chk("rst_valid", m_if.valid, 0);
        chk("rst_data", m_if.data, 0);
        chk("rst_sop", m_if.sop, 0);
        chk("rst_eop", m_if.eop, 0);
        chk("rst_empty", m_if.empty, 0);
        chk("rst_msg_cnt", msg_cnt, 0);
        chk("rst_throttle", thr, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", s_if.ready, 1);
    endtask

    // one clock of stimulus; the model advances on the same edge as the DUT
    task automatic cyc(input bit v, input bit s, input bit e, input logic [EW-1:0] emp, input bit ordy);
        bit rdy, acc, fwd;
        longint t;
        s_if.valid = v; s_if.sop = s; s_if.eop = e; s_if.empty = emp;
        s_if.data = {$urandom(), $urandom(), $urandom(), $urandom()};
        m_if.ready = ordy;
        #2;
        rdy = (!ev || ordy) && (in_msg || !en || cr >= 0);
        chk("in_ready", s_if.ready, rdy);
        acc = v && rdy;
        fwd = acc && (in_msg || s);
        acc_seen = v && s_if.ready;
        if (acc_seen && s) begin gap = cyc_n - last_sop; last_sop = cyc_n; sops++; end
        if (acc_seen && e) eops++;
        cyc_n++;
        if (en && !in_msg && v && s && cr < 0 && thrc < 64'hFFFF_FFFF) thrc++;
        eerr = acc && (in_msg == s);
        if (fwd) begin
            ev = 1; edata = s_if.data; esop = s && !in_msg; eeop = e; eempty = emp;
            if (e) mcnt = (mcnt + 1) % (1 << MW);
        end else if (ordy) ev = 0;
        if (en) begin
            t = cr + longint'(rate);
            if (t > longint'(burst)) t = longint'(burst);
            if (fwd) t -= e ? DW - int'(emp) : DW;
            cr = t < FLR ? FLR : t;
        end else cr = longint'(burst);
        if (acc) in_msg = in_msg ? !e : s && !e;
        @(posedge clk); #1;
        chk("out_valid", m_if.valid, ev);
        chk("out_data", m_if.data, edata);
        chk("out_sop", m_if.sop, esop);
        chk("out_eop", m_if.eop, eeop);
        chk("out_empty", m_if.empty, eempty);
        chk("msg_cnt", msg_cnt, mcnt);
        chk("throttle", thr, thrc);
        chk("err_pulse", err, eerr);
    endtask

    task automatic hit_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        zero_chk();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0]     thr0;
        logic [8*DW-1:0] hold;
        int              n, b;
        s_if.valid = 0; s_if.sop = 0; s_if.eop = 0; s_if.empty = '0; s_if.data = '0;
        m_if.ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        zero_chk();
        rst = 1'b0;

        // bypass: one single-beat message per cycle
        en = 0; rate = 0; burst = 0;
        n = eops;
        repeat (10000) cyc(1, 1, 1, EW'($urandom()), 1);
        chk("byp_beats", eops - n, 10000);
        chk("byp_msgs", msg_cnt, 10000);
        chk("byp_thr", thr, 0);

        // deficit hold: 64 B message from zero credit at 1 B/cycle
        cyc(0, 0, 0, 0, 1);
        en = 1; rate = 1; burst = 1000; thr0 = thr;
        cyc(1, 1, 0, 0, 1); cyc(1, 0, 0, 0, 1); cyc(1, 0, 0, 0, 1); cyc(1, 0, 1, 0, 1);
        chk("def_credit", dut.credit_q, -60);
        n = sops;
        for (int i = 0; i < 200 && sops == n; i++) cyc(1, 1, 1, 0, 1);
        chk("def_gap", gap, 64);
        chk("def_thr", thr - thr0, 60);

        // empty accounting
        en = 0; burst = 20; rate = 0;
        cyc(0, 0, 0, 0, 1);
        en = 1;
        cyc(1, 1, 1, 5, 1);
        chk("emp_out", m_if.empty, 5);
        chk("emp_credit", dut.credit_q, 9);

        // protocol errors
        en = 0;
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("drop_err", err, 1);
        chk("drop_valid", m_if.valid, 0);
        cyc(0, 0, 0, 0, 1);
        chk("drop_err_clr", err, 0);
        cyc(1, 1, 0, 0, 1); cyc(1, 1, 0, 0, 1);
        chk("nest_sop", m_if.sop, 0);
        chk("nest_err", err, 1);
        chk("nest_valid", m_if.valid, 1);
        cyc(1, 0, 1, 0, 1);

        // backpressure mid-message
        cyc(1, 1, 0, 0, 1); cyc(1, 0, 0, 0, 1);
        hold = m_if.data;
        repeat (8) begin
            cyc(1, 0, 0, 0, 0);
            chk("bp_data", m_if.data, hold);
            chk("bp_ready", s_if.ready, 0);
        end
        cyc(1, 0, 1, 0, 1);

        // async reset mid-message, then a non-sop beat must be dropped
        cyc(1, 1, 0, 0, 1); cyc(1, 0, 0, 0, 1);
        hit_reset();
        cyc(1, 0, 0, 0, 1);
        chk("post_rst_drop", err, 1);

        // sustained shaping: 64 B messages at 4 B/cycle settle to one per 16 cycles
        en = 0; burst = 64; rate = 4;
        cyc(0, 0, 0, 0, 1);
        en = 1; n = sops; b = 0;
        for (int i = 0; i < 400 && sops - n < 12; i++) begin
            cyc(1, b == 0, b == 3, 0, 1);
            if (acc_seen) begin
                if (b == 0 && sops - n >= 4) chk("shape_gap", gap, 16);
                b = (b + 1) % 4;
            end
        end
        chk("shape_msgs", sops - n, 12);

        // random traffic, backpressure and config changes
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                en = 1'($urandom_range(0, 1));
                rate = TW'($urandom_range(0, 24));
                burst = TW'($urandom_range(0, 120));
            end
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                EW'($urandom()), $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
